// File: rtl/mem_arb_pkg.sv
// Shared constants for the memory port arbiter: FSM encoding, grant codes,
// default watchdog limit, error read value and the arbitration pick rule.
package mem_arb_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_ACK    = 2'd2;

    typedef logic [1:0] gnt_t;

    localparam gnt_t GNT_NONE = 2'd0;
    localparam gnt_t GNT_IF   = 2'd1;
    localparam gnt_t GNT_D    = 2'd2;
    localparam gnt_t GNT_DBG  = 2'd3;

    localparam int          DEF_TIMEOUT_CYCLES = 255;
    localparam logic [15:0] ERR_RDATA          = 16'hFFFF;

    // Debug wins when it owns the fairness turn or nothing else is asking.
    function automatic gnt_t arb_pick(input logic if_r, input logic d_r,
                                      input logic dbg_r, input logic turn);
        if (dbg_r && (turn || !(if_r || d_r))) return GNT_DBG;
        if (d_r)  return GNT_D;
        if (if_r) return GNT_IF;
        return GNT_NONE;
    endfunction

endpackage

// File: rtl/mem_arb_watchdog.sv
// Loadable down-counter; expired is high once the count has reached zero.
module mem_arb_watchdog #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic          dec,
    input  logic [CW-1:0] load_val,
    output logic          expired
);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                  cnt <= '0;
        else if (load)              cnt <= load_val;
        else if (dec && cnt != '0)  cnt <= cnt - CW'(1);
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Three-way single-port memory arbiter (fetch, data, debug) with req/ready
// memory handshake. Optional access watchdog: define MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW             = 24,
    parameter int DW             = 16,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ack,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_ack,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic [DW-1:0] dbg_rdata,
    output logic          dbg_ack,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    output logic [1:0]    grant,
    output logic          timeout_err
);

    logic [1:0]    state;
    logic          dbg_turn;
    gnt_t          winner;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic          abort;
    logic          done;
    logic [DW-1:0] cap_data;

    assign winner = arb_pick(if_req, d_req, dbg_req, dbg_turn);

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = if_addr;
        sel_wdata = mem_wdata;
        case (winner)
            GNT_D:   begin sel_we = d_we;   sel_addr = d_addr;   sel_wdata = d_wdata;   end
            GNT_DBG: begin sel_we = dbg_we; sel_addr = dbg_addr; sel_wdata = dbg_wdata; end
            default: ;
        endcase
    end

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic wd_expired;

    // Loaded with limit-1 so expiry lands on the last permitted ACCESS cycle.
    mem_arb_watchdog #(.CW(CW)) u_wd (
        .clk      (clk),
        .reset    (reset),
        .load     (state == ST_IDLE && winner != GNT_NONE),
        .dec      (state == ST_ACCESS),
        .load_val (CW'(TIMEOUT_CYCLES - 1)),
        .expired  (wd_expired)
    );

    assign abort = (state == ST_ACCESS) && !mem_ready && wd_expired;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)      timeout_err <= 1'b0;
        else if (abort) timeout_err <= 1'b1;
    end
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign abort       = 1'b0;
    assign timeout_err = 1'b0;
`endif

    assign done     = mem_ready || abort;
    assign cap_data = mem_ready ? mem_rdata : DW'(ERR_RDATA);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            grant     <= GNT_NONE;
            dbg_turn  <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_ack    <= 1'b0;
            d_ack     <= 1'b0;
            dbg_ack   <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            dbg_rdata <= '0;
        end else begin
            if_ack  <= 1'b0;
            d_ack   <= 1'b0;
            dbg_ack <= 1'b0;
            case (state)
                ST_IDLE: if (winner != GNT_NONE) begin
                    state     <= ST_ACCESS;
                    grant     <= winner;
                    mem_req   <= 1'b1;
                    mem_we    <= sel_we;
                    mem_addr  <= sel_addr;
                    mem_wdata <= sel_wdata;
                    if (winner == GNT_DBG) dbg_turn <= 1'b0;
                    else if (dbg_req)      dbg_turn <= 1'b1;
                end
                ST_ACCESS: if (done) begin
                    state   <= ST_ACK;
                    mem_req <= 1'b0;
                    case (grant)
                        GNT_IF:  begin if_ack  <= 1'b1; if (!mem_we) if_rdata  <= cap_data; end
                        GNT_D:   begin d_ack   <= 1'b1; if (!mem_we) d_rdata   <= cap_data; end
                        GNT_DBG: begin dbg_ack <= 1'b1; if (!mem_we) dbg_rdata <= cap_data; end
                        default: ;
                    endcase
                end
                ST_ACK: begin
                    state <= ST_IDLE;
                    grant <= GNT_NONE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized self-checking bench for mem_port_arbiter against a
// transaction-level model of the arbitration, fairness and rdata rules.
module tb_mem_port_arbiter;

    localparam int AW = 24;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // Requester state, index 1 = fetch, 2 = data, 3 = debug
    logic          p_req   [1:3];
    logic          p_we    [1:3];
    logic [AW-1:0] p_addr  [1:3];
    logic [DW-1:0] p_wdata [1:3];
    logic [DW-1:0] m_rdata [1:3];
    bit            turn_m;

    logic [DW-1:0] if_rdata, d_rdata, dbg_rdata, mem_wdata, mem_rdata;
    logic          if_ack, d_ack, dbg_ack, mem_req, mem_we, mem_ready, timeout_err;
    logic [AW-1:0] mem_addr;
    logic [1:0]    grant;

    int n_chk  = 0;
    int n_pass = 0;
    int last   = 0;

    mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .reset(reset),
        .if_req(p_req[1]), .if_addr(p_addr[1]), .if_rdata(if_rdata), .if_ack(if_ack),
        .d_req(p_req[2]), .d_we(p_we[2]), .d_addr(p_addr[2]), .d_wdata(p_wdata[2]),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .dbg_req(p_req[3]), .dbg_we(p_we[3]), .dbg_addr(p_addr[3]), .dbg_wdata(p_wdata[3]),
        .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .grant(grant), .timeout_err(timeout_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic new_req(input int p);
        p_addr[p]  = AW'($urandom);
        p_we[p]    = (p == 1) ? 1'b0 : 1'($urandom_range(0, 1));
        p_wdata[p] = DW'($urandom);
        p_req[p]   = 1'b1;
    endtask

    function automatic bit any_pending();
        return p_req[1] || p_req[2] || p_req[3];
    endfunction

    // Fairness rule: a waiting debug request owns the turn after one CPU grant
    function automatic int model_pick();
        int order [3];
        if (turn_m) order = '{3, 2, 1};
        else        order = '{2, 1, 3};
        foreach (order[i]) if (p_req[order[i]]) return order[i];
        return 0;
    endfunction

    task automatic chk_rdata(input string tag);
        chk({tag, "_if_rdata"},  if_rdata,  m_rdata[1]);
        chk({tag, "_d_rdata"},   d_rdata,   m_rdata[2]);
        chk({tag, "_dbg_rdata"}, dbg_rdata, m_rdata[3]);
    endtask

    // Called during an IDLE cycle with requests already presented.
    task automatic run_txn(input int waits, input logic [DW-1:0] rdat,
                           output int won, output logic [1:0] g_obs);
        int e;
        e = model_pick();
        if (e == 0) begin
            $display("FAIL run_txn: no request pending");
            $fatal(1);
        end
        if (e == 3)        turn_m = 1'b0;
        else if (p_req[3]) turn_m = 1'b1;
        tick();
        g_obs = grant;
        chk("access_req", mem_req, 1);
        chk("access_grant", grant, e);
        chk("cmd_addr", mem_addr, p_addr[e]);
        chk("cmd_we", mem_we, p_we[e]);
        if (p_we[e]) chk("cmd_wdata", mem_wdata, p_wdata[e]);
        for (int i = 0; i < waits; i++) begin
            tick();
            chk("wait_req", mem_req, 1);
            chk("wait_addr", mem_addr, p_addr[e]);
            chk("wait_noack", {dbg_ack, d_ack, if_ack}, 0);
        end
        mem_ready = 1'b1;
        mem_rdata = rdat;
        tick();
        mem_ready = 1'b0;
        mem_rdata = DW'($urandom);
        if (!p_we[e]) m_rdata[e] = rdat;
        chk("ack_onehot", {dbg_ack, d_ack, if_ack}, 3'b001 << (e - 1));
        chk("ack_mem_req", mem_req, 0);
        chk_rdata("ack");
        p_req[e] = 1'b0;
        won = e;
        tick();
        chk("idle_noack", {dbg_ack, d_ack, if_ack}, 0);
        chk("idle_grant", grant, 0);
        chk("idle_mem_req", mem_req, 0);
    endtask

    initial begin
        int          w;
        logic [1:0]  g;
        int          fair_seq [5];
        fair_seq = '{2, 3, 2, 1, 3};

        reset = 1'b1;
        mem_ready = 1'b0;
        mem_rdata = '0;
        turn_m = 1'b0;
        for (int p = 1; p <= 3; p++) begin
            p_req[p] = 1'b0; p_we[p] = 1'b0; p_addr[p] = '0; p_wdata[p] = '0; m_rdata[p] = '0;
        end
        tick();
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_grant", grant, 0);
        chk("rst_acks", {dbg_ack, d_ack, if_ack}, 0);
        chk("rst_timeout", timeout_err, 0);
        chk_rdata("rst");
        reset = 1'b0;
        tick();
        chk("idle_no_req", mem_req, 0);

        // Fetch read, ready in the first mem_req cycle
        new_req(1);
        p_addr[1] = 24'h002400;
        run_txn(0, 16'h1234, last, g);
        chk("fetch_rdata", if_rdata, 16'h1234);

        // Simultaneous fetch and data write: data first, fetch next
        new_req(1);
        new_req(2);
        p_we[2] = 1'b1; p_addr[2] = 24'h001F00; p_wdata[2] = 16'hBEEF;
        run_txn(0, 16'h5555, last, g);
        chk("sim_first", g, 2);
        chk("sim_d_rdata_kept", d_rdata, 16'h0000);
        run_txn(1, 16'h7777, last, g);
        chk("sim_second", g, 1);

        // Debug fairness with the CPU always having something pending
        new_req(1); new_req(2); new_req(3);
        for (int r = 0; r < 5; r++) begin
            run_txn(0, DW'($urandom), last, g);
            chk("fair_seq", g, fair_seq[r]);
            for (int p = 1; p <= 3; p++) if (!p_req[p] && p != last) new_req(p);
        end
        for (int r = 0; r < 4 && any_pending(); r++) run_txn(0, DW'($urandom), last, g);

        // Wait states
        new_req(1);
        run_txn(5, 16'hA5A5, last, g);

`ifdef MEM_ARB_TIMEOUT_EN
        new_req(2);
        p_we[2] = 1'b0;
        tick();
        for (int i = 0; i < 8; i++) begin
            chk("to_wait_req", mem_req, 1);
            chk("to_err_clear", timeout_err, 0);
            tick();
        end
        chk("to_d_ack", d_ack, 1);
        chk("to_d_rdata", d_rdata, 16'hFFFF);
        chk("to_err_set", timeout_err, 1);
        chk("to_mem_req", mem_req, 0);
        m_rdata[2] = 16'hFFFF;
        p_req[2] = 1'b0;
        tick();
        chk("to_err_sticky", timeout_err, 1);
`else
        new_req(2);
        run_txn(20, 16'h0F0F, last, g);
        chk("no_timeout_err", timeout_err, 0);
`endif

        // Reset in the middle of an access
        new_req(1);
        tick();
        chk("mid_access_req", mem_req, 1);
        #2 reset = 1'b1;
        #1;
        chk("async_mem_req", mem_req, 0);
        chk("async_grant", grant, 0);
        chk("async_acks", {dbg_ack, d_ack, if_ack}, 0);
        chk("async_timeout", timeout_err, 0);
        for (int p = 1; p <= 3; p++) begin p_req[p] = 1'b0; m_rdata[p] = '0; end
        turn_m = 1'b0;
        tick();
        chk("rst_hold_acks", {dbg_ack, d_ack, if_ack}, 0);
        chk_rdata("rst2");
        reset = 1'b0;
        tick();
        new_req(1);
        run_txn(1, DW'($urandom), last, g);

        // Randomized traffic
        for (int r = 0; r < 60; r++) begin
            for (int p = 1; p <= 3; p++)
                if (!p_req[p] && p != last && $urandom_range(0, 1) == 1) new_req(p);
            if (!any_pending()) begin
                tick();
                chk("rand_idle_req", mem_req, 0);
                chk("rand_idle_grant", grant, 0);
                last = 0;
                new_req(int'($urandom_range(1, 3)));
            end
            w = int'($urandom_range(0, 3));
            run_txn(w, DW'($urandom), last, g);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Single-port memory arbiter placed between the 16-bit CPU core and the unified 24-bit-address memory. It shares the one memory port between three requesters: instruction fetch, data load/store, and the debug/loader port. It sequences each access through a request/ready handshake with a variable-latency memory, and returns read data with a one-cycle acknowledge. This replaces the core's assumption of same-cycle memory reads.

## Interface
Parameters:
- AW, 24, address width
- DW, 16, data width
- TIMEOUT_CYCLES, 255, watchdog limit in cycles; used only with MEM_ARB_TIMEOUT_EN

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high
- if_req / if_addr  in  1 / AW  fetch request (read only)
- if_rdata / if_ack  out  DW / 1  fetch data; one-cycle ack
- d_req / d_we / d_addr / d_wdata  in  1 / 1 / AW / DW  data request
- d_rdata / d_ack  out  DW / 1  data read result; one-cycle ack
- dbg_req / dbg_we / dbg_addr / dbg_wdata  in  1 / 1 / AW / DW  debug request
- dbg_rdata / dbg_ack  out  DW / 1  debug read result; one-cycle ack
- mem_req / mem_we / mem_addr / mem_wdata  out  1 / 1 / AW / DW  memory command, registered
- mem_rdata / mem_ready  in  DW / 1  memory response; mem_ready may assert in the first mem_req cycle
- grant  out  2  owner of the current access: 0 none, 1 fetch, 2 data, 3 debug
- timeout_err  out  1  sticky watchdog flag

## Operation
- Requester rule: hold req, addr, we and wdata stable until ack. Drop req in the cycle after ack. Req is ignored during the ack cycle.
- FSM states:
  - IDLE: if any req is high, latch the winner's command into mem_* and set grant, then go to ACCESS. With no req, stay in IDLE with mem_req=0 and grant=0.
  - ACCESS: mem_req=1 with the latched command held stable. When mem_ready=1 is sampled, capture mem_rdata into the winner's rdata register (reads only), drop mem_req, and go to ACK.
  - ACK: pulse the winner's ack for one cycle, set grant=0, then return to IDLE.
- Arbitration priority: data > fetch among CPU ports.
- Debug fairness bit dbg_turn:
  - Set when an arbitration grants a CPU port while dbg_req=1.
  - While dbg_turn=1, a pending dbg_req wins over CPU requests.
  - Cleared when debug is granted.
- Writes: rdata is not updated and ack still pulses.
- rdata registers hold their value until that port's next read completes.
- Reset (any time, including mid-ACCESS):
  - Go to IDLE immediately.
  - Outputs: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, all acks 0, all rdata 0, grant=0, dbg_turn=0, timeout_err=0.
  - The in-flight access is abandoned and not acknowledged.

## Timing
- Request sampled in cycle 0, then mem_req=1 in cycle 1.
- mem_ready first high in cycle k (k≥1), then ack in cycle k+1.
- Minimum latency is 2 cycles (req to ack).
- Minimum issue spacing is 3 cycles: IDLE, ACCESS, ACK.
- mem_* outputs change only on IDLE→ACCESS and ACCESS→ACK edges, never while mem_req=1 is awaiting mem_ready.
- A request that arrives during ACCESS or ACK waits and is arbitrated in the next IDLE cycle.

## Configuration
- MEM_ARB_TIMEOUT_EN defined:
  - A counter runs in ACCESS. If mem_ready is still 0 after TIMEOUT_CYCLES cycles in ACCESS, the access aborts: mem_req drops, state goes to ACK, the winner is acked, and its rdata is 16'hFFFF (reads only).
  - timeout_err is set sticky; only reset clears it.
  - The counter clears on entry to ACCESS.
- Undefined: ACCESS waits forever; timeout_err is tied to 0; no counter is present.

## Structure
- Shared package mem_arb_pkg holds:
  - State encoding: IDLE, ACCESS, ACK.
  - Grant constants: GNT_NONE=0, GNT_IF=1, GNT_D=2, GNT_DBG=3.
  - Default TIMEOUT_CYCLES.
  - Error read value 16'hFFFF.
- Sub-module mem_arb_watchdog: loadable down-counter with an expiry flag. It is instantiated only under MEM_ARB_TIMEOUT_EN.

## Test plan
- Fetch read: if_req at 0x002400, memory returns 0x1234 with mem_ready in the first mem_req cycle → mem_addr=0x002400, if_ack 2 cycles after req, if_rdata=0x1234, grant=1 during the access.
- Simultaneous if_req and d_req, with d_we=1, d_addr=0x001F00, d_wdata=0xBEEF → data goes first (mem_we=1, mem_wdata=0xBEEF); fetch is granted in the next IDLE; d_rdata is unchanged.
- Debug fairness: dbg_req held while the CPU issues continuous requests → debug is granted within two arbitrations; the grant sequence is 2,3,2,3….
- Wait states: mem_ready delayed 5 cycles → mem_req and mem_addr stay stable for all 5 cycles; ack arrives one cycle after mem_ready.
- Reset asserted mid-ACCESS → mem_req=0, grant=0 and no ack, asynchronously; after release, a new if_req completes normally.
- With MEM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, mem_ready held 0 → abort after 8 ACCESS cycles; d_ack pulses, d_rdata=0xFFFF, timeout_err=1 until reset.
